// File: rtl/adder_meas_pkg.sv
// Shared types for the adder ring-oscillator measurement sequencer.
// State encoding and fixed sequence lengths.
package adder_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DRAIN,
    CAPTURE
  } meas_state_t;

  localparam int DRAIN_LEN = 2;

endpackage

// File: rtl/edge_sync_counter.sv
// Synchronises the asynchronous ring output and counts its rising edges.
// The count saturates at all-ones; reaching it latches a sticky overflow.
module edge_sync_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             count_en,
  input  logic             chain_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [2:0] sync;
  logic       edge_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], chain_out};
    end
  end

  // sync[1] is the second synchroniser flop, sync[2] its delayed copy
  assign edge_hit = sync[1] & ~sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (count_en && edge_hit) begin
      if (!(&count)) begin
        count <= count + 1'b1;
      end
      if (&count[CNT_W-1:1]) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_ring_measure_ctrl.sv
// Sequencer: load adder operands, settle, run the ring for a window,
// then capture the edge count and adder sum.
module adder_ring_measure_ctrl
  import adder_meas_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 32,
  parameter int SETTLE_CYC = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [WIDTH-1:0] cfg_ext_mask,
  input  logic [WIDTH-1:0] cfg_ring_mask,
  input  logic [CNT_W-1:0] cfg_window,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] result_count,
  output logic [WIDTH-1:0] result_sum,
  output logic [WIDTH-1:0] a_input,
  output logic [WIDTH-1:0] b_input,
  output logic [WIDTH-1:0] a_ext_bit_b,
  output logic [WIDTH-1:0] a_ring_bit_b,
  output logic             ring_en,
  input  logic             chain_out,
  input  logic [WIDTH-1:0] s_output
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_LEN - 1);

  meas_state_t      state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] window;
  logic [CNT_W-1:0] count;
  logic             cnt_clear;
  logic             cnt_en;

  assign cnt_clear = (state == LOAD);
  assign cnt_en    = (state == RUN) || (state == DRAIN);

  edge_sync_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .chain_out(chain_out),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      window       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ring_en      <= 1'b0;
      result_count <= '0;
      result_sum   <= '0;
      a_input      <= '0;
      b_input      <= '0;
      a_ext_bit_b  <= '0;
      a_ring_bit_b <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        ring_en <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            a_input      <= cfg_a;
            b_input      <= cfg_b;
            a_ext_bit_b  <= cfg_ext_mask;
            a_ring_bit_b <= cfg_ring_mask;
            window       <= cfg_window;
            timer        <= SETTLE_LAST;
            state        <= SETTLE;
          end
          SETTLE: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else if (window == '0) begin
              state <= DRAIN;
              timer <= DRAIN_LAST;
            end else begin
              state   <= RUN;
              ring_en <= 1'b1;
              timer   <= window - 1'b1;
            end
          end
          RUN: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              state   <= DRAIN;
              ring_en <= 1'b0;
              timer   <= DRAIN_LAST;
            end
          end
          DRAIN: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            result_count <= count;
            result_sum   <= s_output;
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            ring_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adder_ring_measure_ctrl.sv
// Scoreboard bench for adder_ring_measure_ctrl.
// A second narrow-counter instance exercises saturation.
module tb_adder_ring_measure_ctrl;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_a = '0;
  logic [31:0] cfg_b = '0;
  logic [31:0] cfg_em = '0;
  logic [31:0] cfg_rm = '0;
  logic [31:0] cfg_window = '0;
  logic        chain_out = 1'b0;
  logic        busy, done, overflow, ring_en;
  logic [31:0] result_count, result_sum;
  logic [31:0] a_input, b_input, a_ext, a_ring;
  logic [31:0] s_output;

  logic        start2 = 1'b0;
  logic        chain2 = 1'b0;
  logic [1:0]  win2 = '0;
  logic        busy2, done2, ovf2, ring2;
  logic [1:0]  cnt2;
  logic [31:0] sum2, a2, b2, em2, rm2, s2;

  always #5 clk = ~clk;

  assign s_output = a_input + b_input;
  assign s2 = a2 + b2;

  adder_ring_measure_ctrl #(
    .WIDTH(32), .CNT_W(32), .SETTLE_CYC(S)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .start(start), .abort(abort),
    .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_ext_mask(cfg_em), .cfg_ring_mask(cfg_rm),
    .cfg_window(cfg_window),
    .busy(busy), .done(done), .overflow(overflow),
    .result_count(result_count), .result_sum(result_sum),
    .a_input(a_input), .b_input(b_input),
    .a_ext_bit_b(a_ext), .a_ring_bit_b(a_ring),
    .ring_en(ring_en), .chain_out(chain_out),
    .s_output(s_output)
  );

  adder_ring_measure_ctrl #(
    .WIDTH(32), .CNT_W(2), .SETTLE_CYC(S)
  ) dut2 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .start(start2), .abort(1'b0),
    .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_ext_mask(cfg_em), .cfg_ring_mask(cfg_rm),
    .cfg_window(win2),
    .busy(busy2), .done(done2), .overflow(ovf2),
    .result_count(cnt2), .result_sum(sum2),
    .a_input(a2), .b_input(b2),
    .a_ext_bit_b(em2), .a_ring_bit_b(rm2),
    .ring_en(ring2), .chain_out(chain2),
    .s_output(s2)
  );

  typedef struct {
    logic [31:0] sum;
    int          lo;
    int          hi;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_sum = '0;
  int          last_lo = 0;
  int          last_hi = 0;

  function automatic logic pin(input int c, input int half, input int off);
    if (half == 0) return 1'b0;
    return (((c + off) / half) % 2) == 1;
  endfunction

  task automatic do_run(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] w, input int half,
                        input int off, input int abort_at,
                        input bit chained, input bit hold,
                        input logic [31:0] new_a,
                        input int lo, input int hi);
    int   last;
    bit   ab;
    bit   killed;
    logic eb, er, ed;
    exp_t e;
    last = 5 + S + int'(w);
    ab = (abort_at >= 0);
    if (!ab) begin
      e.sum = a + b; e.lo = lo; e.hi = hi; e.ovf = 1'b0;
      sb.push_back(e);
    end
    for (int c = chained ? 1 : 0; c <= last; c++) begin
      @(negedge clk);
      if (c > 0) begin
        killed = ab && (c > abort_at);
        eb = (c <= 4 + S + int'(w)) && !killed;
        er = (c >= 2 + S) && (c <= 1 + S + int'(w)) && !killed;
        ed = (c == last) && !ab;
        n_checks++;
        if (busy !== eb) begin
          $display("FAIL busy c=%0d got %b want %b", c, busy, eb);
          n_fail++;
        end
        n_checks++;
        if (ring_en !== er) begin
          $display("FAIL ring_en c=%0d got %b want %b", c, ring_en, er);
          n_fail++;
        end
        n_checks++;
        if (done !== ed) begin
          $display("FAIL done c=%0d got %b want %b", c, done, ed);
          n_fail++;
        end
        if (c >= 2) begin
          n_checks++;
          if (a_input !== a) begin
            $display("FAIL a_input c=%0d got %0d want %0d", c, a_input, a);
            n_fail++;
          end
        end
        if (killed) begin
          n_checks++;
          if (result_sum !== last_sum ||
              int'(result_count) < last_lo ||
              int'(result_count) > last_hi) begin
            $display("FAIL abort_hold c=%0d got sum %0d cnt %0d want sum %0d cnt %0d..%0d",
                     c, result_sum, result_count, last_sum, last_lo, last_hi);
            n_fail++;
          end
        end
        if (ed) begin
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty c=%0d got 0 entries want 1", c);
            n_fail++;
          end else begin
            e = sb.pop_front();
            if (result_sum !== e.sum || overflow !== e.ovf ||
                int'(result_count) < e.lo ||
                int'(result_count) > e.hi) begin
              $display("FAIL result got sum %0d cnt %0d ovf %b want sum %0d cnt %0d..%0d ovf %b",
                       result_sum, result_count, overflow,
                       e.sum, e.lo, e.hi, e.ovf);
              n_fail++;
            end
            last_sum = e.sum; last_lo = e.lo; last_hi = e.hi;
          end
        end
      end
      start = (c == 0) || hold;
      abort = (c == abort_at);
      chain_out = pin(c, half, off);
      cfg_a = (c >= 8) ? new_a : a;
      cfg_b = b;
      cfg_window = w;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1;
    cfg_a = 5; cfg_b = 7; cfg_window = 3; chain_out = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, overflow, ring_en} !== 4'b0 ||
        result_count !== '0 || result_sum !== '0 ||
        a_input !== '0 || b_input !== '0 ||
        a_ext !== '0 || a_ring !== '0) begin
      $display("FAIL reset_outputs got busy %b done %b ring %b a %0d sum %0d want all 0",
               busy, done, ring_en, a_input, result_sum);
      n_fail++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL reset_first_load got busy %b want 1", busy);
      n_fail++;
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_input !== 32'd5 || b_input !== 32'd7) begin
      $display("FAIL reset_operands got %0d/%0d want 5/7", a_input, b_input);
      n_fail++;
    end
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL reset_run_timeout got done %b want 1", done);
      n_fail++;
    end else if (result_sum !== 32'd12 || result_count !== '0) begin
      $display("FAIL reset_run_result got sum %0d cnt %0d want 12 0",
               result_sum, result_count);
      n_fail++;
    end
    last_sum = 12; last_lo = 0; last_hi = 0;
  endtask

  task automatic test_basic;
    do_run(5, 7, 10, 4, 0, -1, 1'b0, 1'b0, 5, 2, 3);
  endtask

  task automatic test_zero_window;
    do_run(3, 4, 0, 0, 0, -1, 1'b0, 1'b0, 3, 0, 0);
  endtask

  task automatic test_abort;
    do_run(9, 9, 10, 4, 0, S + 4, 1'b0, 1'b0, 9, 0, 0);
  endtask

  task automatic test_back_to_back;
    do_run(100, 1, 3, 0, 0, -1, 1'b0, 1'b1, 200, 0, 0);
    do_run(200, 2, 3, 0, 0, -1, 1'b1, 1'b0, 200, 0, 0);
  endtask

  task automatic test_overflow;
    int   w, last;
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      w = (r == 0) ? 3 : 2;
      last = 5 + S + w;
      e.sum = '0; e.lo = (r == 0) ? 3 : 2; e.hi = e.lo;
      e.ovf = (r == 0);
      sb.push_back(e);
      for (int c = 0; c <= last; c++) begin
        @(negedge clk);
        if (c == last) begin
          e = sb.pop_front();
          n_checks++;
          if (done2 !== 1'b1 || int'(cnt2) != e.lo || ovf2 !== e.ovf) begin
            $display("FAIL overflow_run%0d got done %b cnt %0d ovf %b want 1 %0d %b",
                     r, done2, cnt2, ovf2, e.lo, e.ovf);
            n_fail++;
          end
        end
        start2 = (c == 0);
        chain2 = pin(c, 1, 1);
        win2 = 2'(w);
      end
    end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    start = 1'b1; cfg_a = 1; cfg_b = 2; cfg_window = 10;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ring_en !== 1'b1) begin
      $display("FAIL midrun_ring got %b want 1", ring_en);
      n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ring_en !== 1'b0 || busy !== 1'b0 ||
        result_sum !== '0 || result_count !== '0) begin
      $display("FAIL midrun_reset got ring %b busy %b sum %0d cnt %0d want 0 0 0 0",
               ring_en, busy, result_sum, result_count);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL midrun_idle got busy %b want 0", busy);
      n_fail++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_window();
    test_abort();
    test_back_to_back();
    test_overflow();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
